sipo_deserializer: RTL and testbench

//   Serial-in/parallel-out front end for the PIPO register stage. Collects

---
 rtl/sipo_deserializer.sv | 72 +++++++
 tb/tb_sipo_deserializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: gathers WIDTH serial bits under valid/ready
// and presents each complete word on a held parallel output with its own valid/ready.
`default_nettype none

module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic             s_data,
   input  logic             s_start,
   output logic             s_ready,
   output logic             p_valid,
   output logic [WIDTH-1:0] p_data,
   input  logic             p_ready
);

   localparam int                 CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] next_word;
   logic             accept;
   logic             complete;

   // Only the completing bit stalls, and only while the previous word is still unconsumed.
   always_comb begin
      s_ready   = !((cnt == LAST) && p_valid && !p_ready);
      accept    = s_valid && s_ready;
      complete  = accept && !s_start && (cnt == LAST);
      base      = s_start ? '0 : shreg;
      next_word = '0;
      if (MSB_FIRST) begin
         next_word = {base[WIDTH-2:0], s_data};
      end else begin
         next_word = {s_data, base[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         shreg   <= '0;
         p_data  <= '0;
         p_valid <= 1'b0;
      end else begin
         if (accept) begin
            shreg <= next_word;
            if (s_start) begin
               cnt <= CNT_W'(1);
            end else if (cnt == LAST) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
         if (complete) begin
            p_data  <= next_word;
            p_valid <= 1'b1;
         end else if (p_ready) begin
            p_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances driven in parallel,
// checked against directed vector tables and a bit-queue reference model.
`default_nettype none

module tb_sipo_deserializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         s_valid = 1'b0, s_data = 1'b0, s_start = 1'b0, p_ready = 1'b0;
   logic         sr_m, sr_l, pv_m, pv_l;
   logic [W-1:0] pd_m, pd_l;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_start(s_start),
      .s_ready(sr_m), .p_valid(pv_m), .p_data(pd_m), .p_ready(p_ready));

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_start(s_start),
      .s_ready(sr_l), .p_valid(pv_l), .p_data(pd_l), .p_ready(p_ready));

   // Reference model: the bits of the word in progress, in arrival order.
   bit           q[$];
   bit           m_pv = 1'b0;
   logic [W-1:0] m_wm = '0;
   logic [W-1:0] m_wl = '0;
   logic         last_sr_m, last_sr_l;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pv = 1'b0;
      m_wm = '0;
      m_wl = '0;
   endtask

   function automatic logic model_sready(input logic pr);
      return !((q.size() == W - 1) && m_pv && !pr);
   endfunction

   task automatic model_edge(input logic v, input logic d, input logic st, input logic pr);
      bit acc;
      bit done;
      acc  = v && model_sready(pr);
      done = 1'b0;
      if (acc) begin
         if (st) begin
            q.delete();
            q.push_back(d);
         end else begin
            q.push_back(d);
            if (q.size() == W) begin
               done = 1'b1;
               for (int i = 0; i < W; i++) begin
                  m_wm[W-1-i] = q[i];
                  m_wl[i]     = q[i];
               end
               q.delete();
            end
         end
      end
      if (done) m_pv = 1'b1;
      else if (m_pv && pr) m_pv = 1'b0;
   endtask

   // One clock: drive, check s_ready before the edge, advance model, check outputs after.
   task automatic step(input logic v, input logic d, input logic st, input logic pr);
      s_valid = v; s_data = d; s_start = st; p_ready = pr;
      #1;
      last_sr_m = sr_m;
      last_sr_l = sr_l;
      chk("s_ready_msb", {3'b0, sr_m}, {3'b0, model_sready(pr)});
      chk("s_ready_lsb", {3'b0, sr_l}, {3'b0, model_sready(pr)});
      @(posedge clk);
      model_edge(v, d, st, pr);
      #1;
      chk("p_valid_msb", {3'b0, pv_m}, {3'b0, m_pv});
      chk("p_valid_lsb", {3'b0, pv_l}, {3'b0, m_pv});
      chk("p_data_msb", pd_m, m_wm);
      chk("p_data_lsb", pd_l, m_wl);
   endtask

   typedef struct {
      logic         v, d, st, pr;
      logic         e_sr;
      logic         e_pv;
      logic [W-1:0] e_pm;
      logic [W-1:0] e_pl;
   } vec_t;

   vec_t tbl[31];
   int   pulses;

   initial begin
      tbl[0]  = '{1,1,1,1, 1,0,4'b0000,4'b0000};
      tbl[1]  = '{1,0,0,1, 1,0,4'b0000,4'b0000};
      tbl[2]  = '{1,1,0,1, 1,0,4'b0000,4'b0000};
      tbl[3]  = '{1,1,0,1, 1,1,4'b1011,4'b1101};
      tbl[4]  = '{0,0,0,1, 1,0,4'b1011,4'b1101};
      tbl[5]  = '{1,1,1,0, 1,0,4'b1011,4'b1101};
      tbl[6]  = '{1,1,0,0, 1,0,4'b1011,4'b1101};
      tbl[7]  = '{1,0,0,0, 1,0,4'b1011,4'b1101};
      tbl[8]  = '{1,0,0,0, 1,1,4'b1100,4'b0011};
      tbl[9]  = '{1,0,1,0, 1,1,4'b1100,4'b0011};
      tbl[10] = '{1,1,0,0, 1,1,4'b1100,4'b0011};
      tbl[11] = '{1,0,0,0, 1,1,4'b1100,4'b0011};
      tbl[12] = '{1,1,0,0, 0,1,4'b1100,4'b0011};
      tbl[13] = '{1,1,0,1, 1,1,4'b0101,4'b1010};
      tbl[14] = '{0,0,0,1, 1,0,4'b0101,4'b1010};
      tbl[15] = '{1,1,1,1, 1,0,4'b0101,4'b1010};
      tbl[16] = '{1,0,0,1, 1,0,4'b0101,4'b1010};
      tbl[17] = '{1,0,0,1, 1,0,4'b0101,4'b1010};
      tbl[18] = '{1,0,0,1, 1,1,4'b1000,4'b0001};
      tbl[19] = '{1,0,1,1, 1,0,4'b1000,4'b0001};
      tbl[20] = '{1,0,0,1, 1,0,4'b1000,4'b0001};
      tbl[21] = '{1,0,0,1, 1,0,4'b1000,4'b0001};
      tbl[22] = '{1,1,0,1, 1,1,4'b0001,4'b1000};
      tbl[23] = '{0,0,0,1, 1,0,4'b0001,4'b1000};
      tbl[24] = '{1,1,1,1, 1,0,4'b0001,4'b1000};
      tbl[25] = '{1,1,0,1, 1,0,4'b0001,4'b1000};
      tbl[26] = '{1,1,1,1, 1,0,4'b0001,4'b1000};
      tbl[27] = '{1,0,0,1, 1,0,4'b0001,4'b1000};
      tbl[28] = '{1,0,0,1, 1,0,4'b0001,4'b1000};
      tbl[29] = '{1,1,0,1, 1,1,4'b1001,4'b1001};
      tbl[30] = '{0,0,0,1, 1,0,4'b1001,4'b1001};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_p_valid", {3'b0, pv_m}, 4'b0);
      chk("reset_p_data", pd_m, 4'b0);
      rst = 1'b1;
      #1;
      chk("reset_s_ready", {3'b0, sr_m}, 4'b0001);

      // Directed vectors: first bit, restart, back-pressure, both bit orders.
      for (int i = 0; i < 31; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].st, tbl[i].pr);
         chk($sformatf("tbl%0d_s_ready", i), {3'b0, last_sr_m}, {3'b0, tbl[i].e_sr});
         chk($sformatf("tbl%0d_p_valid", i), {3'b0, pv_m}, {3'b0, tbl[i].e_pv});
         chk($sformatf("tbl%0d_p_data_msb", i), pd_m, tbl[i].e_pm);
         chk($sformatf("tbl%0d_p_data_lsb", i), pd_l, tbl[i].e_pl);
      end

      // Asynchronous reset mid-word with a held output word.
      step(1, 1, 1, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
      step(1, 0, 1, 0); step(1, 1, 0, 0);
      chk("pre_reset_p_valid", {3'b0, pv_m}, 4'b0001);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_p_valid", {3'b0, pv_m}, 4'b0);
      chk("async_rst_p_data", pd_m, 4'b0);
      chk("async_rst_p_data_lsb", pd_l, 4'b0);
      model_reset();
      #2 rst = 1'b1;
      step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1);
      chk("post_rst_word", pd_m, 4'b0110);

      // Continuous stream A,5,F with p_ready always high: one pulse per word, no stall.
      pulses = 0;
      for (int w = 0; w < 3; w++) begin
         logic [W-1:0] word;
         word = (w == 0) ? 4'hA : (w == 1) ? 4'h5 : 4'hF;
         for (int b = W - 1; b >= 0; b--) begin
            step(1, word[b], 1'b0, 1);
            chk("stream_s_ready", {3'b0, last_sr_m}, 4'b0001);
            if (pv_m) pulses++;
         end
         chk("stream_word", pd_m, word);
      end
      chk("stream_pulses", 4'(pulses), 4'd3);

      // Randomised traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
